alu_exec_ctrl: RTL and testbench

Multi-cycle execute controller that issues operations to the combinational `alu` and retires their results. It accepts one 32-bit instruction at a time and fetches memory operands over a req/ack bus. It drives the ALU operand and instruction ports, writes back the accumulator, carry/borrow flag and extension register, and resolves branches and halt. It sits between instruction fetch and the datapath; the `alu` itself is instantiated beside it at the parent level.

---
 rtl/isa_pkg.sv | 78 +++++++
 rtl/alu_exec_ctrl_if.sv | 25 ++
 rtl/alu_exec_ctrl.sv | 119 +++++++++++
 tb/tb_alu_exec_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Opcode constants, controller state encoding and instruction-class decode
// shared by the execute controller and the ALU.
package isa_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 8;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP   = 8'h00;
    localparam opcode_t OP_STORE = 8'h01;
    localparam opcode_t OP_LOAD  = 8'h02;
    localparam opcode_t OP_BUN   = 8'h03;
    localparam opcode_t OP_BZ    = 8'h04;
    localparam opcode_t OP_BP    = 8'h05;
    localparam opcode_t OP_SII   = 8'h06;
    localparam opcode_t OP_ADD   = 8'h07;
    localparam opcode_t OP_SUB   = 8'h08;
    localparam opcode_t OP_MUL   = 8'h09;
    localparam opcode_t OP_DIV   = 8'h0A;
    localparam opcode_t OP_AND   = 8'h0B;
    localparam opcode_t OP_OR    = 8'h0C;
    localparam opcode_t OP_XOR   = 8'h0D;
    localparam opcode_t OP_NOR   = 8'h0E;
    localparam opcode_t OP_NAND  = 8'h0F;
    localparam opcode_t OP_NOT   = 8'h16;
    localparam opcode_t OP_INC   = 8'h17;
    localparam opcode_t OP_DEC   = 8'h18;
    localparam opcode_t OP_SR    = 8'h19;
    localparam opcode_t OP_SL    = 8'h20;
    localparam opcode_t OP_AR    = 8'h21;
    localparam opcode_t OP_CIR   = 8'h22;
    localparam opcode_t OP_CIL   = 8'h23;
    localparam opcode_t OP_HLT   = 8'h24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEM_RD = 3'd1,
        ST_MEM_WR = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic logic is_binary(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
                          OP_OR, OP_XOR, OP_NOR, OP_NAND};
    endfunction

    function automatic logic is_unary(input opcode_t op);
        return op inside {OP_NOT, OP_INC, OP_DEC, OP_SR, OP_SL,
                          OP_AR, OP_CIR, OP_CIL};
    endfunction

    function automatic logic is_mem(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Binary ALU ops need their second operand fetched, exactly like LOAD.
    function automatic state_t entry_state(input opcode_t op);
        if (op == OP_HLT)
            return ST_HALT;
        if (op == OP_STORE)
            return ST_MEM_WR;
        if (is_binary(op) || is_mem(op))
            return ST_MEM_RD;
        return ST_EXEC;
    endfunction

    function automatic logic branch_taken(input opcode_t op, input logic [DATA_W-1:0] acc);
        case (op)
            OP_BUN:  return 1'b1;
            OP_BZ:   return acc == '0;
            OP_BP:   return !acc[DATA_W-1] && (acc != '0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake and memory req/ack bus between the execute
// controller (master) and its fetch/memory environment (slave).
interface alu_exec_ctrl_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        input  inst_valid, inst, mem_ack, mem_rdata,
        output inst_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output inst_valid, inst, mem_ack, mem_rdata,
        input  inst_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller: accepts one instruction, fetches/stores
// memory operands, drives the external ALU and retires results.
module alu_exec_ctrl
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_ctrl_if.master   bus,
    output logic [31:0]       alu_inst,
    output logic [31:0]       alu_op1,
    output logic [31:0]       alu_op2,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       alu_ext,
    input  logic              alu_cb,
    output logic              br_valid,
    output logic [ADDR_W-1:0] br_target,
    output logic [31:0]       ac,
    output logic [31:0]       ext,
    output logic              cb,
    output logic              done,
    output logic              halted
);

    state_t      state;
    logic [31:0] ir;
    logic [31:0] mdr;
    opcode_t     inst_op;
    opcode_t     ir_op;
    state_t      inst_entry;

    assign inst_op    = bus.inst[31:24];
    assign ir_op      = ir[31:24];
    assign inst_entry = entry_state(inst_op);

    assign alu_inst = ir;
    assign alu_op1  = ac;
    assign alu_op2  = mdr;

    // A STORE retires in its ack cycle, so done is decoded from state and ack.
    assign done = (state == ST_EXEC) || ((state == ST_MEM_WR) && bus.mem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            ir             <= '0;
            mdr            <= '0;
            ac             <= '0;
            ext            <= '0;
            cb             <= 1'b0;
            bus.inst_ready <= 1'b1;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            br_valid       <= 1'b0;
            br_target      <= '0;
            halted         <= 1'b0;
        end else begin
            br_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.inst_valid && bus.inst_ready) begin
                        ir             <= bus.inst;
                        state          <= inst_entry;
                        bus.inst_ready <= 1'b0;
                        // Bus fields latch once at accept and hold through the ack.
                        bus.mem_req    <= (inst_entry == ST_MEM_RD) || (inst_entry == ST_MEM_WR);
                        bus.mem_we     <= (inst_entry == ST_MEM_WR);
                        bus.mem_addr   <= bus.inst[ADDR_W-1:0];
                        bus.mem_wdata  <= ac;
                        br_target      <= bus.inst[ADDR_W-1:0];
                        br_valid       <= branch_taken(inst_op, ac);
                        halted         <= (inst_entry == ST_HALT);
                    end
                end
                ST_MEM_RD: begin
                    if (bus.mem_ack) begin
                        mdr         <= bus.mem_rdata;
                        bus.mem_req <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end
                ST_MEM_WR: begin
                    if (bus.mem_ack) begin
                        bus.mem_req    <= 1'b0;
                        bus.inst_ready <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (is_binary(ir_op) || is_unary(ir_op)) begin
                        ac <= alu_result;
                        cb <= alu_cb;
                        if ((ir_op == OP_MUL) || (ir_op == OP_DIV))
                            ext <= alu_ext;
                    end else if (ir_op == OP_LOAD) begin
                        ac <= mdr;
                    end else if (ir_op == OP_SII) begin
                        ac <= {8'h00, ir[23:0]};
                    end
                    bus.inst_ready <= 1'b1;
                    state          <= ST_IDLE;
                end
                ST_HALT: begin
                    halted         <= 1'b1;
                    bus.inst_ready <= 1'b0;
                end
                default: begin
                    bus.inst_ready <= 1'b1;
                    bus.mem_req    <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU and a
// handshake-driven memory responder.
module tb_alu_exec_ctrl;
    import isa_pkg::*;

    localparam int unsigned ADDR_W = 24;

    logic              clk;
    logic              rst;
    logic [31:0]       alu_inst, alu_op1, alu_op2;
    logic [31:0]       alu_result, alu_ext;
    logic              alu_cb;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic [31:0]       ac, ext;
    logic              cb, done, halted;

    int tests;
    int fails;

    alu_exec_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    alu_exec_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_inst   (alu_inst),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .alu_ext    (alu_ext),
        .alu_cb     (alu_cb),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .ac         (ac),
        .ext        (ext),
        .cb         (cb),
        .done       (done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Reference ALU: only the operations exercised here need real behaviour.
    always_comb begin
        logic [32:0] s;
        logic [63:0] p;
        s          = '0;
        p          = '0;
        alu_result = '0;
        alu_ext    = '0;
        alu_cb     = 1'b0;
        case (alu_inst[31:24])
            OP_ADD: begin s = {1'b0, alu_op1} + {1'b0, alu_op2}; alu_result = s[31:0]; alu_cb = s[32]; end
            OP_SUB: begin s = {1'b0, alu_op1} - {1'b0, alu_op2}; alu_result = s[31:0]; alu_cb = s[32]; end
            OP_MUL: begin p = {32'h0, alu_op1} * {32'h0, alu_op2}; alu_result = p[31:0]; alu_ext = p[63:32]; end
            OP_DIV: begin
                if (alu_op2 == '0) alu_cb = 1'b1;
                else begin alu_result = alu_op1 / alu_op2; alu_ext = alu_op1 % alu_op2; end
            end
            OP_AND: alu_result = alu_op1 & alu_op2;
            OP_NOT: alu_result = ~alu_op1;
            OP_INC: begin s = {1'b0, alu_op1} + 33'd1; alu_result = s[31:0]; alu_cb = s[32]; end
            OP_DEC: begin s = {1'b0, alu_op1} - 33'd1; alu_result = s[31:0]; alu_cb = s[32]; end
            default: alu_result = '0;
        endcase
    end

    // Offers one instruction for a single accept edge; returns mid-cycle T+1.
    task automatic send(input opcode_t op, input logic [23:0] imm);
        @(negedge clk);
        bus.inst_valid = 1'b1;
        bus.inst       = {op, imm};
        @(negedge clk);
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
    endtask

    // Acks the pending request in its cyc-th request cycle; returns mid-cycle A+1.
    task automatic mem_serve(input int cyc, input logic [31:0] data, output int held);
        int guard;
        guard = 0;
        held  = 0;
        while (bus.mem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (bus.mem_req !== 1'b1) begin
            fails++;
            $display("FAIL mem_req_wait: mem_req=%b after %0d cycles, required 1", bus.mem_req, guard);
            return;
        end
        for (int i = 1; i <= cyc; i++) begin
            if (bus.mem_req === 1'b1) held++;
            if (i == cyc) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = data;
            end
            @(negedge clk);
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++; if (bus.inst_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.inst_ready); end
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        tests++; if (done !== 1'b0 || br_valid !== 1'b0 || halted !== 1'b0) begin
            fails++; $display("FAIL reset_pulses: done=%b br_valid=%b halted=%b want 0", done, br_valid, halted);
        end
        tests++; if (ac !== 32'h0 || ext !== 32'h0 || cb !== 1'b0) begin
            fails++; $display("FAIL reset_regs: ac=%h ext=%h cb=%b want 0", ac, ext, cb);
        end
    endtask

    task automatic test_sii_inc;
        send(OP_SII, 24'h000005);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL sii_done: got %b want 1", done); end
        @(negedge clk);
        tests++; if (ac !== 32'h5) begin fails++; $display("FAIL sii_ac: got %h want 00000005", ac); end
        tests++; if (done !== 1'b0 || bus.inst_ready !== 1'b1) begin
            fails++; $display("FAIL sii_retire: done=%b ready=%b want 0/1", done, bus.inst_ready);
        end
        send(OP_INC, 24'h0);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL inc_done: got %b want 1", done); end
        @(negedge clk);
        tests++; if (ac !== 32'h6 || cb !== 1'b0) begin fails++; $display("FAIL inc_result: ac=%h cb=%b want 00000006/0", ac, cb); end
    endtask

    task automatic test_add_delayed;
        int held;
        send(OP_LOAD, 24'h000020);
        mem_serve(1, 32'hFFFF_FFFF, held);
        @(negedge clk);
        tests++; if (ac !== 32'hFFFF_FFFF || ext !== 32'h0) begin fails++; $display("FAIL load_ac: ac=%h ext=%h want ffffffff/0", ac, ext); end
        send(OP_ADD, 24'h000030);
        tests++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 24'h30) begin
            fails++; $display("FAIL add_req: we=%b addr=%h want 0/000030", bus.mem_we, bus.mem_addr);
        end
        mem_serve(3, 32'h1, held);
        tests++; if (held !== 3) begin fails++; $display("FAIL add_req_held: got %0d want 3", held); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL add_done: got %b want 1", done); end
        @(negedge clk);
        tests++; if (ac !== 32'h0 || cb !== 1'b1 || ext !== 32'h0) begin
            fails++; $display("FAIL add_result: ac=%h cb=%b ext=%h want 0/1/0", ac, cb, ext);
        end
    endtask

    task automatic test_mul_div;
        int held;
        send(OP_SII, 24'h000007);
        @(negedge clk);
        send(OP_MUL, 24'h000040);
        mem_serve(1, 32'h8000_0000, held);
        @(negedge clk);
        tests++; if (ac !== 32'h8000_0000 || ext !== 32'h3 || cb !== 1'b0) begin
            fails++; $display("FAIL mul_result: ac=%h ext=%h cb=%b want 80000000/3/0", ac, ext, cb);
        end
        send(OP_DIV, 24'h000044);
        mem_serve(2, 32'h0, held);
        @(negedge clk);
        tests++; if (ac !== 32'h0 || ext !== 32'h0 || cb !== 1'b1) begin
            fails++; $display("FAIL div0_result: ac=%h ext=%h cb=%b want 0/0/1", ac, ext, cb);
        end
    endtask

    task automatic test_branch;
        int held;
        send(OP_BZ, 24'h000100);
        tests++; if (br_valid !== 1'b1 || br_target !== 24'h100 || done !== 1'b1) begin
            fails++; $display("FAIL bz_taken: br_valid=%b target=%h done=%b want 1/000100/1", br_valid, br_target, done);
        end
        @(negedge clk);
        tests++; if (br_valid !== 1'b0) begin fails++; $display("FAIL bz_pulse: got %b want 0", br_valid); end
        send(OP_LOAD, 24'h000050);
        mem_serve(1, 32'h8000_0000, held);
        @(negedge clk);
        send(OP_BP, 24'h000200);
        tests++; if (br_valid !== 1'b0 || done !== 1'b1) begin
            fails++; $display("FAIL bp_negative: br_valid=%b done=%b want 0/1", br_valid, done);
        end
        @(negedge clk);
    endtask

    task automatic test_store;
        int held;
        send(OP_LOAD, 24'h000060);
        mem_serve(1, 32'hDEAD_BEEF, held);
        @(negedge clk);
        send(OP_STORE, 24'h000010);
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 24'h10) begin
            fails++; $display("FAIL store_req: req=%b we=%b wdata=%h addr=%h want 1/1/deadbeef/000010",
                              bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL store_early_done: got %b want 0", done); end
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        tests++; if (done !== 1'b1 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL store_ack: done=%b wdata=%h want 1/deadbeef", done, bus.mem_wdata);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        tests++; if (bus.inst_ready !== 1'b1 || bus.mem_req !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL store_retire: ready=%b req=%b done=%b want 1/0/0", bus.inst_ready, bus.mem_req, done);
        end
    endtask

    task automatic test_rst_mid_load;
        send(OP_SII, 24'h0);
        @(negedge clk);
        send(OP_LOAD, 24'h000070);
        tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL abort_req: got %b want 1", bus.mem_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (bus.mem_req !== 1'b0 || bus.inst_ready !== 1'b1 || ac !== 32'h0) begin
            fails++; $display("FAIL abort_state: req=%b ready=%b ac=%h want 0/1/0", bus.mem_req, bus.inst_ready, ac);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234;
        #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL stray_ack_done: got %b want 0", done); end
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        tests++; if (ac !== 32'h0 || bus.inst_ready !== 1'b1) begin
            fails++; $display("FAIL stray_ack_ac: ac=%h ready=%b want 0/1", ac, bus.inst_ready);
        end
    endtask

    task automatic test_halt;
        send(OP_HLT, 24'h0);
        tests++; if (halted !== 1'b1 || bus.inst_ready !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL halt_entry: halted=%b ready=%b done=%b want 1/0/0", halted, bus.inst_ready, done);
        end
        bus.inst_valid = 1'b1;
        bus.inst       = {OP_SII, 24'h000055};
        repeat (8) @(negedge clk);
        tests++; if (halted !== 1'b1 || bus.inst_ready !== 1'b0 || ac !== 32'h0) begin
            fails++; $display("FAIL halt_hold: halted=%b ready=%b ac=%h want 1/0/0", halted, bus.inst_ready, ac);
        end
        bus.inst_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (halted !== 1'b0 || bus.inst_ready !== 1'b1) begin
            fails++; $display("FAIL halt_exit: halted=%b ready=%b want 0/1", halted, bus.inst_ready);
        end
        send(OP_SII, 24'h000009);
        @(negedge clk);
        tests++; if (ac !== 32'h9) begin fails++; $display("FAIL post_halt_sii: got %h want 00000009", ac); end
    endtask

    initial begin
        clk            = 1'b0;
        rst            = 1'b1;
        tests          = 0;
        fails          = 0;
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        test_reset();
        test_sii_inc();
        test_add_delayed();
        test_mul_div();
        test_branch();
        test_store();
        test_rst_mid_load();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
